// File: rtl/src_p_reorder_buffer.sv
// Reorder buffer behind the per-bank vertex BRAM read stage: collects out-of-order
// lane results per slot and releases complete 4-lane groups strictly in allocation order.
module src_p_reorder_buffer #(
    parameter int SRC_P_DWIDTH  = 32,
    parameter int ROB_PTR_WIDTH = 5,
    parameter int LOC_Y_WIDTH   = 2,
    parameter int IN_NUM        = 4,
    parameter int AM_LEVEL      = 28
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              alloc_valid,
    input  logic [3:0]                        alloc_mask,
    output logic                              alloc_full,
    input  logic [IN_NUM*SRC_P_DWIDTH-1:0]    in_src_p,
    input  logic [IN_NUM*ROB_PTR_WIDTH-1:0]   in_loc_x,
    input  logic [IN_NUM*LOC_Y_WIDTH-1:0]     in_loc_y,
    input  logic [IN_NUM-1:0]                 in_valid,
    input  logic                              back_stage_full,
    output logic [4*SRC_P_DWIDTH-1:0]         out_src_p,
    output logic [3:0]                        out_mask,
    output logic                              out_valid,
    output logic                              err
);
    localparam int DEPTH = 2 ** ROB_PTR_WIDTH;
    localparam int LANES = 4;
    localparam logic [ROB_PTR_WIDTH:0] DEPTH_C = (ROB_PTR_WIDTH+1)'(DEPTH);
    localparam logic [ROB_PTR_WIDTH:0] AM_C    = (ROB_PTR_WIDTH+1)'(AM_LEVEL);

    logic [ROB_PTR_WIDTH:0]         alloc_cntr;
    logic [ROB_PTR_WIDTH:0]         rd_cntr;
    logic [ROB_PTR_WIDTH:0]         occ;
    logic [ROB_PTR_WIDTH-1:0]       head_slot;
    logic [ROB_PTR_WIDTH-1:0]       alloc_slot;
    logic [3:0]                     exp_mask [DEPTH];
    logic [3:0]                     arr_mask [DEPTH];
    logic [LANES*SRC_P_DWIDTH-1:0]  slot_data [DEPTH];
    logic [3:0]                     head_exp;
    logic [3:0]                     head_arr;
    logic [LANES*SRC_P_DWIDTH-1:0]  head_data;
    logic                           alloc_ok;
    logic                           alloc_drop;
    logic                           retire_silent;
    logic                           retire_out;
    logic                           retire;

    logic [ROB_PTR_WIDTH-1:0]       loc_x [IN_NUM];
    logic [LOC_Y_WIDTH-1:0]         loc_y [IN_NUM];
    logic [SRC_P_DWIDTH-1:0]        src_p [IN_NUM];
    logic [ROB_PTR_WIDTH-1:0]       rel   [IN_NUM];
    logic [IN_NUM-1:0]              hit;
    logic [IN_NUM-1:0]              bad;

    assign occ        = alloc_cntr - rd_cntr;
    assign head_slot  = rd_cntr[ROB_PTR_WIDTH-1:0];
    assign alloc_slot = alloc_cntr[ROB_PTR_WIDTH-1:0];
    assign head_exp   = exp_mask[head_slot];
    assign head_arr   = arr_mask[head_slot];
    assign alloc_full = rst | (occ >= AM_C);

    assign alloc_ok      = alloc_valid && (occ < DEPTH_C);
    assign alloc_drop    = alloc_valid && !alloc_ok;
    // Empty groups still occupy a slot so loc_x stays aligned; they drain without a stall check.
    assign retire_silent = (occ != '0) && (head_exp == 4'b0000);
    assign retire_out    = (occ != '0) && (head_exp != 4'b0000) && (head_arr == head_exp) && !back_stage_full;
    assign retire        = retire_silent | retire_out;

    always_comb begin
        for (int i = 0; i < IN_NUM; i++) begin
            loc_x[i] = in_loc_x[i*ROB_PTR_WIDTH +: ROB_PTR_WIDTH];
            loc_y[i] = in_loc_y[i*LOC_Y_WIDTH +: LOC_Y_WIDTH];
            src_p[i] = in_src_p[i*SRC_P_DWIDTH +: SRC_P_DWIDTH];
            rel[i]   = loc_x[i] - head_slot;
        end
    end

    // A result is accepted only into a live, non-retiring slot on a lane that group expects.
    always_comb begin
        hit = '0;
        bad = '0;
        for (int i = 0; i < IN_NUM; i++) begin
            if (in_valid[i]) begin
                if (({1'b0, rel[i]} < occ) && exp_mask[loc_x[i]][loc_y[i]] &&
                    !(retire && (loc_x[i] == head_slot))) begin
                    hit[i] = 1'b1;
                    if (arr_mask[loc_x[i]][loc_y[i]]) bad[i] = 1'b1;
                end else begin
                    bad[i] = 1'b1;
                end
                for (int j = 0; j < i; j++) begin
                    if (in_valid[j] && (loc_x[j] == loc_x[i]) && (loc_y[j] == loc_y[i])) bad[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        head_data = '0;
        for (int l = 0; l < LANES; l++) begin
            if (head_exp[l]) head_data[l*SRC_P_DWIDTH +: SRC_P_DWIDTH] = slot_data[head_slot][l*SRC_P_DWIDTH +: SRC_P_DWIDTH];
        end
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_slot
        localparam logic [ROB_PTR_WIDTH-1:0] SLOT = ROB_PTR_WIDTH'(s);
        logic [3:0]                    exp_r;
        logic [3:0]                    arr_r;
        logic [LANES*SRC_P_DWIDTH-1:0] data_r;

        always_ff @(posedge clk) begin
            if (rst) begin
                exp_r <= '0;
                arr_r <= '0;
            end else if (alloc_ok && (alloc_slot == SLOT)) begin
                exp_r <= alloc_mask;
                arr_r <= '0;
            end else begin
                for (int l = 0; l < LANES; l++) begin
                    for (int i = 0; i < IN_NUM; i++) begin
                        if (hit[i] && (loc_x[i] == SLOT) && (loc_y[i] == LOC_Y_WIDTH'(l))) arr_r[l] <= 1'b1;
                    end
                end
            end
        end

        // Higher-numbered inputs are visited last, so they win on a same-lane collision.
        always_ff @(posedge clk) begin
            for (int l = 0; l < LANES; l++) begin
                for (int i = 0; i < IN_NUM; i++) begin
                    if (hit[i] && (loc_x[i] == SLOT) && (loc_y[i] == LOC_Y_WIDTH'(l)))
                        data_r[l*SRC_P_DWIDTH +: SRC_P_DWIDTH] <= src_p[i];
                end
            end
        end

        assign exp_mask[s]  = exp_r;
        assign arr_mask[s]  = arr_r;
        assign slot_data[s] = data_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_cntr <= '0;
            rd_cntr    <= '0;
            err        <= 1'b0;
            out_valid  <= 1'b0;
            out_mask   <= '0;
            out_src_p  <= '0;
        end else begin
            if (alloc_ok) alloc_cntr <= alloc_cntr + 1'b1;
            if (retire)   rd_cntr    <= rd_cntr + 1'b1;
            if (alloc_drop || (|bad)) err <= 1'b1;
            out_valid <= retire_out;
            out_mask  <= retire_out ? head_exp : 4'b0000;
            out_src_p <= retire_out ? head_data : '0;
        end
    end

endmodule
